// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the CPU core and its memory-side blocks.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Types and constants shared by the set-associative instruction cache and its victim selector.
package icache_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/icache_victim_sel.sv
// Replacement choice for one set: lowest-numbered invalid way, else the round-robin pointer.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic [WAY_W-1:0] victim,
    output logic             evict
);
    always_comb begin
        evict  = &valid_vec;
        victim = rr_ptr;
        // Descending scan so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) victim = WAY_W'(w);
        end
    end
endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word blocks, round-robin replacement and flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_assoc
    import icache_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 8,
    parameter int BLK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  word_t       imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output word_t       imemload,
    output logic        iREN,
    output word_t       iaddr,
    input  logic        iwait,
    input  word_t       iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int WOFF      = $clog2(BLK_WORDS);
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = 32 - 2 - WOFF - IDX_W;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W     = (WOFF > 0) ? WOFF : 1;
    localparam int BLK_BYTES = BLK_WORDS * WORD_BYTES;

    typedef struct packed {
        logic                    valid;
        logic [TAG_W-1:0]        tag;
        word_t [BLK_WORDS-1:0]   data;
    } frame_t;

    function automatic logic [IDX_W-1:0] idx_of(input word_t a);
        return IDX_W'(a >> (2 + WOFF));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input word_t a);
        return TAG_W'(a >> (2 + WOFF + IDX_W));
    endfunction

    function automatic logic [CNT_W-1:0] woff_of(input word_t a);
        return CNT_W'((a >> 2) & word_t'(BLK_WORDS - 1));
    endfunction

    frame_t             frames [WAYS][SETS];
    logic [WAY_W-1:0]   rr     [SETS];

    icache_state_t      state, next_state;
    logic [CNT_W-1:0]   cnt;
    word_t              base;
    logic [WAY_W-1:0]   fill_way;
    logic               fill_evict;
    logic               flush_pend;

    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [CNT_W-1:0]   req_woff;
    logic [WAYS-1:0]    set_valid, way_match;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    word_t              hit_word;
    logic [WAY_W-1:0]   victim;
    logic               evict;
    logic               start_fill, accept, last_word;

    assign req_idx  = idx_of(imemaddr);
    assign req_tag  = tag_of(imemaddr);
    assign req_woff = woff_of(imemaddr);
    assign fill_idx = idx_of(base);

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = frames[w][req_idx].valid;
            way_match[w] = frames[w][req_idx].valid && (frames[w][req_idx].tag == req_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) hit_way = WAY_W'(w);
        end
        hit      = |way_match;
        hit_word = frames[hit_way][req_idx].data[req_woff];
    end

    icache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .valid_vec (set_valid),
        .rr_ptr    (rr[req_idx]),
        .victim    (victim),
        .evict     (evict)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        start_fill = 1'b0;
        accept     = 1'b0;
        last_word  = 1'b0;
        case (state)
            IDLE: begin
                // A flush cycle neither hits nor starts a fill.
                if (imemREN && !iflush) begin
                    if (hit) begin
                        ihit     = 1'b1;
                        imemload = hit_word;
                    end else begin
                        start_fill = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = base + (word_t'(cnt) << 2);
                if (!iwait) begin
                    accept = 1'b1;
                    if (cnt == CNT_W'(BLK_WORDS - 1)) begin
                        last_word  = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (start_fill) begin
            base       <= imemaddr & ~word_t'(BLK_BYTES - 1);
            fill_way   <= victim;
            fill_evict <= evict;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            flush_pend <= 1'b0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            if (start_fill) begin
                cnt        <= '0;
                flush_pend <= 1'b0;
            end
            if (state == FILL && iflush) flush_pend <= 1'b1;
            if (accept) cnt <= cnt + 1'b1;
            if (last_word && fill_evict) begin
                rr[fill_idx] <= (fill_way == WAY_W'(WAYS - 1)) ? '0 : fill_way + 1'b1;
            end
        end
    end

    // Tag and data are never reset; only the valid bits are cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) frames[w][s].valid <= 1'b0;
        end else begin
            if (state == IDLE && iflush) begin
                for (int w = 0; w < WAYS; w++)
                    for (int s = 0; s < SETS; s++) frames[w][s].valid <= 1'b0;
            end
            if (accept) frames[fill_way][fill_idx].data[cnt] <= iload;
            if (last_word) begin
                frames[fill_way][fill_idx].tag <= tag_of(base);
                if (flush_pend || iflush) begin
                    for (int w = 0; w < WAYS; w++)
                        for (int s = 0; s < SETS; s++) frames[w][s].valid <= 1'b0;
                end else begin
                    frames[fill_way][fill_idx].valid <= 1'b1;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (ihit)       hit_cnt  <= sat_inc(hit_cnt);
            if (start_fill) miss_cnt <= sat_inc(miss_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: directed scenarios plus randomized fetch/flush traffic.
module tb_icache_assoc;
    localparam int WAYS = 2;
    localparam int SETS = 8;
    localparam int BLK  = 2;

    logic        CLK, RST, imemREN, iflush, ihit, iREN, iwait;
    logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLK_WORDS(BLK)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    always_comb iload = memf(iaddr);

    // Reference model: which blocks are resident, by set and way.
    bit          mvalid [WAYS][SETS];
    int unsigned mtag   [WAYS][SETS];
    int          mrr    [SETS];
    int unsigned m_hits, m_misses;

    function automatic int set_of(input logic [31:0] a);
        return int'((a / (4 * BLK)) % SETS);
    endfunction

    function automatic int unsigned tagv(input logic [31:0] a);
        return a / (4 * BLK * SETS);
    endfunction

    function automatic logic [31:0] blk_base(input logic [31:0] a);
        return a - (a % (4 * BLK));
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (mvalid[w][s] && mtag[w][s] == tagv(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        int s = set_of(a);
        int v = -1;
        for (int w = 0; w < WAYS; w++)
            if (!mvalid[w][s] && v < 0) v = w;
        if (v < 0) begin
            v = mrr[s];
            mrr[s] = (mrr[s] + 1) % WAYS;
        end
        mvalid[v][s] = 1'b1;
        mtag[v][s]   = tagv(a);
    endfunction

    function automatic void model_flush();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) mvalid[w][s] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    typedef struct {
        logic [31:0] data;
        bit          miss;
        int          exp_ren;
    } hit_exp_t;

    hit_exp_t    hit_q[$];
    logic [31:0] fill_q[$];
    int          checks, errors;
    bit          mon_en;
    int          iwait_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event not seen within 400 cycles", name);
        hit_q.delete();
        fill_q.delete();
    endtask

    // Monitor: consumes expectations whenever the DUT accepts a fill word or signals a hit.
    int       wait_c, ren_c, fword;
    hit_exp_t e;
    always @(negedge CLK) begin
        if (!mon_en) begin
            wait_c = 0;
            ren_c  = 0;
            fword  = 0;
        end else begin
            if (iflush) chk("ihit_in_flush_cycle", {31'd0, ihit}, 32'd0);
            if (iREN) begin
                if (fill_q.size() == 0) chk("unexpected_fill", {31'd0, iREN}, 32'd0);
                else begin
                    chk("fill_addr", iaddr, fill_q[0] + 32'(4 * fword));
                    if (!iwait) begin
                        fword++;
                        if (fword == BLK) begin
                            void'(fill_q.pop_front());
                            fword = 0;
                        end
                    end
                end
                if (imemREN) ren_c++;
            end
            if (ihit) begin
                if (hit_q.size() == 0) chk("unexpected_hit", {31'd0, ihit}, 32'd0);
                else begin
                    e = hit_q.pop_front();
                    chk("imemload", imemload, e.data);
                    chk("hit_latency", 32'(wait_c), e.miss ? 32'(ren_c + 1) : 32'd0);
                    if (e.exp_ren >= 0) chk("fill_cycles", 32'(ren_c), 32'(e.exp_ren));
                end
                wait_c = 0;
                ren_c  = 0;
            end else if (imemREN) begin
                wait_c++;
            end else begin
                wait_c = 0;
                ren_c  = 0;
            end
        end
    end

    initial begin
        int sc = 0;
        iwait = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (iwait_mode)
                1: iwait = ($urandom_range(0, 2) == 0);
                2: begin
                    if (iREN && sc < 3) begin
                        iwait = 1'b1;
                        sc++;
                    end else begin
                        iwait = 1'b0;
                        sc = 0;
                    end
                end
                default: iwait = 1'b0;
            endcase
        end
    end

    task automatic wait_hit();
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge CLK);
            if (ihit) seen = 1'b1;
        end
        if (!seen) timeout_fail("hit_timeout");
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_ren);
        bit h = model_hit(a);
        if (!h) begin
            model_fill(a);
            fill_q.push_back(blk_base(a));
            m_misses++;
        end
        m_hits++;
        hit_q.push_back('{data: memf(a), miss: !h, exp_ren: exp_ren});
        @(posedge CLK);
        #1;
        imemREN  = 1'b1;
        imemaddr = a;
        wait_hit();
    endtask

    task automatic flush_idle(input bit with_req, input logic [31:0] a);
        @(posedge CLK);
        #1;
        iflush   = 1'b1;
        imemREN  = with_req;
        imemaddr = a;
        @(posedge CLK);
        #1;
        iflush  = 1'b0;
        imemREN = 1'b0;
        model_flush();
    endtask

    task automatic fetch_flush_mid(input logic [31:0] a);
        bit done = 1'b0;
        if (model_hit(a)) begin
            fetch(a, -1);
            return;
        end
        model_fill(a);
        fill_q.push_back(blk_base(a));
        m_misses++;
        model_flush();
        @(posedge CLK);
        #1;
        imemREN  = 1'b1;
        imemaddr = a;
        @(posedge CLK);
        #1;
        iflush  = 1'b1;
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        iflush = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK);
            if (!iREN) done = 1'b1;
        end
        if (!done) timeout_fail("fill_end_timeout");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            imemREN = 1'b0;
        end
    endtask

    task automatic check_stats();
        idle(1);
        @(negedge CLK);
`ifdef ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        iwait_mode = 0;
        RST = 1'b1;
        imemREN = 1'b0;
        imemaddr = '0;
        iflush = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mon_en = 1'b1;

        // Cold miss, then the second word of the same block hits.
        fetch(32'h40, BLK);
        fetch(32'h44, 0);
        check_stats();

        // Two fills, eviction of way0, round-robin then moves to way1.
        fetch(32'h80, BLK);
        fetch(32'hC0, BLK);
        fetch(32'h80, 0);
        fetch(32'h40, BLK);
        fetch(32'hC4, -1);

        // Three wait cycles before every word.
        flush_idle(1'b0, 32'h0);
        iwait_mode = 2;
        fetch(32'h40, 4 * BLK);
        iwait_mode = 0;

        // Flush with a resident line requested in the same cycle.
        fetch(32'h40, 0);
        flush_idle(1'b1, 32'h40);
        fetch(32'h40, BLK);

        // Flush arriving during the first fill word.
        flush_idle(1'b0, 32'h0);
        fetch_flush_mid(32'h40);
        fetch(32'h40, BLK);

        // Reset at fill word 1 aborts the fill.
        flush_idle(1'b0, 32'h0);
        mon_en = 1'b0;
        @(posedge CLK);
        #1;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("fill_word1_iaddr", iaddr, 32'h44);
        RST = 1'b1;
        imemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("iREN_after_rst", {31'd0, iREN}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        hit_q.delete();
        fill_q.delete();
        mon_en = 1'b1;
        check_stats();
        fetch(32'h40, BLK);

        // Randomized traffic over a small address pool to force hits and evictions.
        for (int n = 0; n < 400; n++) begin
            int op = int'($urandom_range(0, 99));
            logic [31:0] a;
            iwait_mode = (n % 100 < 50) ? 1 : 0;
            a = 32'($urandom_range(0, 3) * 4 * BLK * SETS + $urandom_range(0, 3) * 4 * BLK
                    + $urandom_range(0, BLK - 1) * 4);
            if (op < 80)       fetch(a, -1);
            else if (op < 88)  flush_idle(1'($urandom_range(0, 1)), a);
            else if (op < 95)  fetch_flush_mid(a);
            else               idle(int'($urandom_range(1, 3)));
        end
        iwait_mode = 0;
        check_stats();
        idle(2);
        chk("hit_q_drained", 32'(hit_q.size()), 32'd0);
        chk("fill_q_drained", 32'(fill_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
